logic_unit_mc: RTL and testbench

Parametrised multi-cycle logic unit for the execute stage. It computes any of the 16 two-input bitwise functions from a 4-bit truth-table code, plus iterative count-leading-zeros and count-leading-ones (CLZ/CLO). Operands and results pass through valid/ready handshakes, so the pipeline controller can stall on multi-cycle count operations.

---
 rtl/logic_unit_mc.sv | 139 +++++++++++++
 tb/tb_logic_unit_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_mc.sv
// Multi-cycle logic unit: 16 truth-table bitwise functions plus chunked CLZ/CLO.
// Optional `LOGIC_CLZ_EARLY_EXIT_EN ends the count scan at the first chunk holding a hit.
module logic_unit_mc #(
    parameter int          WIDTH        = 32,
    parameter int          CHUNK        = 8,
    parameter int unsigned ERROR_OUTPUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ft,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int JW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] scan;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    add;
    logic [JW-1:0]    j;
    logic             hit;
    logic [CHUNK-1:0] chunk;
    logic [WIDTH-1:0] bitwise;
    logic             accept;
    logic             last;
    logic             scan_end;

    function automatic logic [CW-1:0] chunk_lz(input logic [CHUNK-1:0] c);
        logic [CW-1:0] n;
        logic          seen;
        n    = '0;
        seen = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (c[i])
                seen = 1'b1;
            else if (!seen)
                n = n + CW'(1);
        end
        return n;
    endfunction

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its data while valid is high, and ready never depends on valid.
    always_comb begin
        bitwise = '0;
        for (int i = 0; i < WIDTH; i++)
            bitwise[i] = ft[{b[i], a[i]}];

        // The scan register shifts left, so the current chunk is always at the top.
        chunk = scan[WIDTH-1 -: CHUNK];
        add   = '0;
        if (!hit)
            add = (chunk == '0) ? CW'(CHUNK) : chunk_lz(chunk);
        cnt_next = cnt + add;
        last     = (j == JW'(NCH - 1));
`ifdef LOGIC_CLZ_EARLY_EXIT_EN
        scan_end = last || (chunk != '0);
`else
        scan_end = last;
`endif
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_valid = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            err    <= 1'b0;
            cnt    <= '0;
            j      <= '0;
            hit    <= 1'b0;
            scan   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        case (op)
                            2'b00: begin
                                result <= bitwise;
                                err    <= 1'b0;
                                state  <= DONE;
                            end
                            2'b11: begin
                                result <= WIDTH'(ERROR_OUTPUT);
                                err    <= 1'b1;
                                state  <= DONE;
                            end
                            default: begin
                                // CLO is CLZ of the inverted operand.
                                scan  <= op[1] ? ~a : a;
                                cnt   <= '0;
                                j     <= '0;
                                hit   <= 1'b0;
                                state <= SCAN;
                            end
                        endcase
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    cnt  <= cnt_next;
                    scan <= scan << CHUNK;
                    j    <= j + JW'(1);
                    if (chunk != '0)
                        hit <= 1'b1;
                    if (scan_end) begin
                        result <= WIDTH'(cnt_next);
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_mc.sv
// Directed bench for logic_unit_mc: vector table plus streaming, backpressure and reset sequences.
module tb_logic_unit_mc;

    localparam int W = 32;
`ifdef LOGIC_CLZ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ft;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         err;
    logic [1:0]   dbg_state;

    logic_unit_mc #(.WIDTH(W), .CHUNK(8), .ERROR_OUTPUT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ft(ft), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]   op;
        logic [3:0]   ft;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           exp_k;
    } vec_t;

    vec_t         vq[$];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add_vec(input logic [1:0] o, input logic [3:0] f, input logic [W-1:0] xa,
                           input logic [W-1:0] xb, input logic [W-1:0] r, input logic e,
                           input int k_early, input int k_full);
        vec_t v;
        v.op = o; v.ft = f; v.a = xa; v.b = xb;
        v.exp_res = r; v.exp_err = e;
        v.exp_k = EARLY ? k_early : k_full;
        vq.push_back(v);
    endtask

    // driver tasks
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [3:0] f, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, output logic [W-1:0] res, output logic e,
                          output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; ft = f; a = xa; b = xb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after acceptance: the unit must have sampled them already.
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        ft = 4'($urandom_range(0, 15));
        op = 2'($urandom_range(0, 3));
        wait_result(lat);
        res = result;
        e   = err;
    endtask

    initial begin
        logic [W-1:0] res;
        logic         e;
        int           lat;
        logic         stale;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ft = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;

        // op, ft, a, b, result, err, k(early), k(full); k = cycles waited after acceptance
        add_vec(2'b00, 4'b1000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 0, 0);
        add_vec(2'b00, 4'b0110, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, 0, 0);
        add_vec(2'b00, 4'b0001, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 1'b0, 0, 0);
        add_vec(2'b00, 4'b1110, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 0, 0);
        add_vec(2'b00, 4'b1010, 32'hF0F000FF, 32'h0FF00F0F, 32'hF0F000FF, 1'b0, 0, 0);
        add_vec(2'b00, 4'b1100, 32'hF0F000FF, 32'h0FF00F0F, 32'h0FF00F0F, 1'b0, 0, 0);
        add_vec(2'b00, 4'b0000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00000000, 1'b0, 0, 0);
        add_vec(2'b00, 4'b1111, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFFFFFFF, 1'b0, 0, 0);
        add_vec(2'b11, 4'b1010, 32'h12345678, 32'h9ABCDEF0, 32'h00000001, 1'b1, 0, 0);
        add_vec(2'b01, 4'b0000, 32'h00010000, 32'hFFFFFFFF, 32'd15,       1'b0, 2, 4);
        add_vec(2'b01, 4'b0000, 32'h00000000, 32'h0,        32'd32,       1'b0, 4, 4);
        add_vec(2'b10, 4'b0000, 32'hFFFFFFFF, 32'h0,        32'd32,       1'b0, 4, 4);
        add_vec(2'b10, 4'b0000, 32'hFFF00000, 32'h0,        32'd12,       1'b0, 2, 4);
        add_vec(2'b01, 4'b0000, 32'h00000001, 32'h0,        32'd31,       1'b0, 4, 4);
        add_vec(2'b01, 4'b0000, 32'h80000000, 32'h0,        32'd0,        1'b0, 1, 4);
        add_vec(2'b10, 4'b0000, 32'h7FFFFFFF, 32'h0,        32'd0,        1'b0, 1, 4);
        add_vec(2'b01, 4'b0000, 32'h00FF0000, 32'h0,        32'd8,        1'b0, 2, 4);
        add_vec(2'b10, 4'b0000, 32'hFFFFFF7F, 32'h0,        32'd24,       1'b0, 4, 4);
        add_vec(2'b11, 4'b0110, 32'h0,        32'h0,        32'h00000001, 1'b1, 0, 0);
        add_vec(2'b00, 4'b0110, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 0, 0);

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].ft, vq[i].a, vq[i].b, res, e, lat);
            check($sformatf("vec%0d result", i), 64'(res), 64'(vq[i].exp_res));
            check($sformatf("vec%0d err", i), 64'(e), 64'(vq[i].exp_err));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vq[i].exp_k));
        end

        // back-to-back bitwise stream with out_ready held high
        exp_q.push_back(32'h00F0000F);
        exp_q.push_back(32'hFF000FF0);
        exp_q.push_back(32'h000FF000);
        op = 2'b00; a = 32'hF0F000FF; b = 32'h0FF00F0F;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ft = (i == 0) ? 4'b1000 : (i == 1) ? 4'b0110 : 4'b0001;
            check($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            check($sformatf("stream%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d result", i), 64'(result), 64'(exp_q.pop_front()));
        end
        in_valid = 1'b0;

        // backpressure on a reserved-op result, next op waiting at the input
        op = 2'b11; a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = 2'b01; a = 32'h00000001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d result", i), 64'(result), 64'd1);
            check($sformatf("hold%0d err", i), 64'(err), 64'd1);
            check($sformatf("hold%0d in_ready", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release accepts same edge", 64'(dbg_state), 64'd1);
        check("release out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        wait_result(lat);
        check("release result", 64'(result), 64'd31);
        check("release err", 64'(err), 64'd0);
        check("release latency", 64'(lat), 64'd4);

        // reset in the middle of a CLZ scan
        op = 2'b01; a = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midscan state", 64'(dbg_state), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset result", 64'(result), 64'd0);
        check("async reset state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post reset in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("no stale result", 64'(stale), 64'd0);
        run_op(2'b01, 4'b0000, 32'h80000000, 32'h0, res, e, lat);
        check("post reset result", 64'(res), 64'd0);
        check("post reset err", 64'(e), 64'd0);
        check("post reset latency", 64'(lat), EARLY ? 64'd1 : 64'd4);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
